// File: rtl/conv_window_feeder.sv
// conv_window_feeder: serial weight loader and raster-to-3x3-window feeder for the convolution engine
module conv_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_valid,
  input  logic [7:0]  w_in,
  output logic        w_ready,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  output logic        pix_ready,
  output logic        weight_valid,
  output logic [71:0] weight_bus,
  output logic        in_valid,
  output logic [71:0] ifm_bus,
  output logic        frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  typedef enum logic [1:0] {IDLE, LOAD_W, READY, STREAM} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0] wcnt;
  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  logic [7:0] win [9];
  logic [7:0] nwin [9];
  logic [7:0] wsh [8];
  logic w_acc, p_acc, last_col, last_pix, win_ok;
  assign w_ready = state != STREAM;
  assign pix_ready = state == STREAM || (state == READY && !w_valid);
  assign w_acc = w_valid && w_ready;
  assign p_acc = pix_valid && pix_ready;
  assign last_col = col == COL_MAX;
  assign last_pix = last_col && row == ROW_MAX;
  assign win_ok = row >= RW'(2) && col >= CW'(2);
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nwin[3*r]   = win[3*r+1];
      nwin[3*r+1] = win[3*r+2];
    end
    nwin[2] = lb2[col];
    nwin[5] = lb1[col];
    nwin[8] = pix_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      wcnt         <= '0;
      weight_bus   <= '0;
      ifm_bus      <= '0;
      weight_valid <= 1'b0;
      in_valid     <= 1'b0;
      frame_done   <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win[i] <= '0;
      for (int i = 0; i < 8; i++) wsh[i] <= '0;
    end else begin
      weight_valid <= 1'b0;
      in_valid     <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (w_acc) begin
            wsh[0] <= w_in;
            wcnt   <= 4'd1;
            state  <= LOAD_W;
          end else if (p_acc) begin
            state <= STREAM;
          end
        end
        LOAD_W: begin
          if (w_acc) begin
            wcnt <= wcnt == 4'd8 ? 4'd0 : wcnt + 4'd1;
            if (wcnt == 4'd8) begin
              weight_bus   <= {w_in, wsh[7], wsh[6], wsh[5], wsh[4], wsh[3], wsh[2], wsh[1], wsh[0]};
              weight_valid <= 1'b1;
              state        <= READY;
            end else begin
              wsh[wcnt[2:0]] <= w_in;
            end
          end
        end
        STREAM: if (p_acc && last_pix) state <= READY;
      endcase
      if (p_acc) begin
        lb2[col] <= lb1[col];
        lb1[col] <= pix_in;
        for (int i = 0; i < 9; i++) win[i] <= nwin[i];
        if (win_ok) begin
          ifm_bus    <= {nwin[8], nwin[7], nwin[6], nwin[5], nwin[4], nwin[3], nwin[2], nwin[1], nwin[0]};
          in_valid   <= 1'b1;
          frame_done <= last_pix;
        end
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? (last_pix ? '0 : row + 1'b1) : row;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: randomized and directed checks against a frame-level reference model
module tb_conv_window_feeder;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;
  localparam logic [71:0] FIRST0 = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] LAST0  = {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45};
  localparam logic [71:0] FIRST1 = {8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63};
  logic clk, rst_n, w_valid, w_ready, pix_valid, pix_ready;
  logic weight_valid, in_valid, frame_done;
  logic [7:0] w_in, pix_in;
  logic [71:0] weight_bus, ifm_bus;
  int n_chk, n_fail, n_win, n_fd;
  logic m_have, m_load, m_strm, e_wv, e_iv, e_fd;
  int m_wn, m_pn;
  logic [71:0] e_wbus, e_ifm;
  logic [7:0] img [H][W];
  logic [7:0] mbuf [9];

  conv_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_in(w_in), .w_ready(w_ready),
    .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready),
    .weight_valid(weight_valid), .weight_bus(weight_bus),
    .in_valid(in_valid), .ifm_bus(ifm_bus), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_w_rdy();
    return !m_strm;
  endfunction

  function automatic logic m_p_rdy();
    return m_strm || (m_have && !m_load && !w_valid);
  endfunction

  // Reference model: weights collected in a list, pixels placed into a frame image by arrival index
  initial forever begin
    logic wa, pa;
    int r, c;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_have = 0; m_load = 0; m_strm = 0; m_wn = 0; m_pn = 0;
      e_wv = 0; e_iv = 0; e_fd = 0; e_wbus = '0; e_ifm = '0;
    end else begin
      wa = w_valid && m_w_rdy();
      pa = pix_valid && m_p_rdy();
      e_wv = 0; e_iv = 0; e_fd = 0;
      if (wa) begin
        mbuf[m_wn] = w_in;
        m_wn++;
        m_load = 1;
        if (m_wn == 9) begin
          for (int k = 0; k < 9; k++) e_wbus[8*k +: 8] = mbuf[k];
          e_wv = 1; m_wn = 0; m_load = 0; m_have = 1;
        end
      end
      if (pa) begin
        r = m_pn / W;
        c = m_pn % W;
        img[r][c] = pix_in;
        if (r >= 2 && c >= 2) begin
          for (int k = 0; k < 9; k++) e_ifm[8*k +: 8] = img[r-2+k/3][c-2+k%3];
          e_iv = 1;
          e_fd = m_pn == N - 1;
        end
        m_pn++;
        m_strm = 1;
        if (m_pn == N) begin
          m_pn = 0;
          m_strm = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("w_ready", w_ready, m_w_rdy());
    chk("pix_ready", pix_ready, m_p_rdy());
    chk("weight_valid", weight_valid, e_wv);
    chk("weight_bus", weight_bus, e_wbus);
    chk("in_valid", in_valid, e_iv);
    chk("ifm_bus", ifm_bus, e_ifm);
    chk("frame_done", frame_done, e_fd);
    if (in_valid) n_win++;
    if (frame_done) n_fd++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [7:0] b, input int gap);
    int n;
    logic got;
    w_valid = 0;
    repeat (gap) cyc();
    w_valid = 1; w_in = b; got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = w_ready;
      @(posedge clk);
      #1;
      n++;
    end
    w_valid = 0;
    chk("w_accept", got, 1'b1);
  endtask

  task automatic send_p(input logic [7:0] p, input int gap);
    int n;
    logic got;
    pix_valid = 0;
    repeat (gap) cyc();
    pix_valid = 1; pix_in = p; got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end
    pix_valid = 0;
    chk("pix_accept", got, 1'b1);
  endtask

  task automatic load_w(input logic rnd);
    for (int k = 0; k < 9; k++)
      send_w(rnd ? 8'($urandom) : 8'(k + 1), rnd ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic frame(input int pm, input int gm);
    logic [7:0] p;
    int g;
    for (int i = 0; i < N; i++) begin
      p = pm == 0 ? 8'(i) : pm == 1 ? 8'(63 - i) : 8'($urandom);
      g = gm == 0 ? 0 : gm == 1 ? (i == 0 ? 0 : 1) : int'($urandom_range(0, 2));
      send_p(p, g);
      if (i == 2 * W + 2 && pm < 2) begin
        chk("first_in_valid", in_valid, 1'b1);
        chk("first_window", ifm_bus, pm == 0 ? FIRST0 : FIRST1);
      end
      if (i == N - 1 && pm == 0) begin
        chk("last_window", ifm_bus, LAST0);
        chk("last_frame_done", frame_done, 1'b1);
      end
    end
  endtask

  initial begin
    int s, f;
    n_chk = 0; n_fail = 0; n_win = 0; n_fd = 0;
    rst_n = 0; w_valid = 0; w_in = 0; pix_valid = 0; pix_in = 0;
    repeat (3) cyc();
    chk("rst_weight_bus", weight_bus, 72'h0);
    chk("rst_ifm_bus", ifm_bus, 72'h0);
    chk("rst_w_ready", w_ready, 1'b1);
    chk("rst_pix_ready", pix_ready, 1'b0);
    rst_n = 1;
    cyc();
    // weights 1..9 back to back
    load_w(0);
    chk("t1_weight_valid", weight_valid, 1'b1);
    chk("t1_weight_bus", weight_bus, 72'h090807060504030201);
    cyc();
    chk("t1_pulse_width", weight_valid, 1'b0);
    // continuous frame, then toggled frame
    s = n_win; f = n_fd;
    frame(0, 0);
    cyc();
    chk("t2_windows", n_win - s, 36);
    chk("t2_frame_done", n_fd - f, 1);
    s = n_win;
    frame(0, 1);
    cyc();
    chk("t3_windows", n_win - s, 36);
    // simultaneous weight and pixel requests in READY
    w_valid = 1; w_in = 8'hFF; pix_valid = 1; pix_in = 8'd7;
    @(negedge clk);
    chk("t4_pix_ready", pix_ready, 1'b0);
    @(posedge clk);
    #1;
    pix_valid = 0;
    for (int k = 0; k < 8; k++) send_w(8'hFF, 0);
    chk("t4_weight_valid", weight_valid, 1'b1);
    chk("t4_weight_bus", weight_bus, {72{1'b1}});
    cyc();
    // reset mid-frame
    for (int i = 0; i < 20; i++) send_p(8'(i), 0);
    #2 rst_n = 0;
    #1;
    chk("t5_in_valid", in_valid, 1'b0);
    chk("t5_ifm_bus", ifm_bus, 72'h0);
    chk("t5_weight_bus", weight_bus, 72'h0);
    chk("t5_pix_ready", pix_ready, 1'b0);
    chk("t5_frame_done", frame_done, 1'b0);
    repeat (2) cyc();
    rst_n = 1;
    s = n_win;
    pix_valid = 1; pix_in = 8'd5;
    repeat (5) cyc();
    pix_valid = 0;
    chk("t5_no_window", n_win, s);
    load_w(1);
    s = n_win;
    frame(2, 2);
    cyc();
    chk("t5_windows", n_win - s, 36);
    // back-to-back frames
    load_w(0);
    s = n_win; f = n_fd;
    frame(0, 0);
    frame(1, 0);
    cyc();
    chk("t6_windows", n_win - s, 72);
    chk("t6_frame_done", n_fd - f, 2);
    // randomized reloads and frames
    for (int j = 0; j < 4; j++) begin
      load_w(1);
      s = n_win;
      frame(2, 2);
      cyc();
      chk("rand_windows", n_win - s, 36);
    end
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
Front-end transmitter for the 3x3 convolution datapath. It collects 9 serial weight bytes and presents them in parallel with a one-cycle weight_valid pulse. It then takes a raster-order pixel stream, buffers two image lines plus a 3x3 window, and emits one parallel 9-pixel window with a one-cycle in_valid pulse per valid output position. Its outputs drive the convolution engine's weight_valid/In_Weight_1..9 and in_valid/In_IFM_1..9 inputs directly.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
w_valid  input  1  serial weight byte valid
w_in  input  8  weight byte, row-major order k=1..9
w_ready  output  1  weight byte accepted when w_valid && w_ready
pix_valid  input  1  pixel valid
pix_in  input  8  pixel byte, raster order
pix_ready  output  1  pixel accepted when pix_valid && pix_ready
weight_valid  output  1  one-cycle pulse, new weight set on weight_bus
weight_bus  output  72  weight k at bits [8k-1:8k-8]
in_valid  output  1  one-cycle pulse, new window on ifm_bus
ifm_bus  output  72  window element k at bits [8k-1:8k-8]
frame_done  output  1  pulse coincident with the last in_valid of a frame

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low. Reset clears FSM to IDLE, all counters, line buffers, window, weight_bus, ifm_bus, weight_valid, in_valid and frame_done to 0.
- FSM states: IDLE, LOAD_W, READY, STREAM.
  - IDLE: w_ready=1, pix_ready=0. Accepted byte -> stored as weight 1, wcnt=1, go to LOAD_W.
  - LOAD_W: w_ready=1, pix_ready=0. Each accepted byte is stored at index wcnt+1. On the 9th byte: go to READY; weight_bus updates and weight_valid=1 on the next edge, for exactly 1 cycle.
  - READY: w_ready=1, pix_ready=!w_valid, so weights win simultaneous requests. An accepted weight byte starts a reload: weight 1 stored, go to LOAD_W; weight_bus keeps its old value until the 9th byte. An accepted pixel is stored at (row 0, col 0); go to STREAM.
  - STREAM: w_ready=0, pix_ready=1. On acceptance of pixel (IMG_H-1, IMG_W-1): go to READY, counters wrap to 0.
- Gaps in w_valid or pix_valid are stalls. No state or counter advances without acceptance.
- Pixel path:
  - col counts 0..IMG_W-1; row increments at col wrap.
  - Two IMG_W-deep line buffers hold rows r-1 and r-2.
  - The 3x3 window shifts left on each accepted pixel. The new column is {linebuf2[col], linebuf1[col], pix_in}.
- Window validity: the accepted pixel at (row,col) with row>=2 and col>=2 produces a window. in_valid=1 on the next edge, for 1 cycle. There are no windows across row boundaries (col<2 suppressed).
- Window mapping: element k maps to position r=(k-1)/3, c=(k-1)%3, which is pixel (row-2+r, col-2+c). Element 9 is the current pixel.
- ifm_bus and weight_bus are registered and hold their values between pulses.
- Windows per frame: (IMG_H-2)*(IMG_W-2). frame_done=1 in the same cycle as the in_valid for pixel (IMG_H-1, IMG_W-1).
- Latency: 1 cycle from the accepting edge to in_valid/weight_valid.
- Back-to-back frames are allowed. Only pixel_ready and the FSM gate them; there is no bubble required between frames.
- Reset mid-frame or mid-load: immediate return to IDLE. The partial frame is discarded and no pulses follow. Weights must be reloaded.

Test Plan:
1. Weights 1..9 on consecutive cycles from IDLE -> weight_valid single pulse 1 cycle after the 9th acceptance; weight_bus = 0x090807060504030201; w_ready low never in LOAD_W.
2. 8x8 frame, pix=row*8+col, pix_valid continuous -> first in_valid 1 cycle after pixel 18 accepted, ifm_bus elements 1..9 = 0,1,2,8,9,10,16,17,18; exactly 36 in_valid pulses; last window = 45,46,47,53,54,55,61,62,63 with frame_done=1.
3. Same frame with pix_valid toggling 1/0 every cycle -> identical 36 windows in the same order, each in_valid exactly 1 cycle after its accepting edge, no duplicates.
4. In READY, w_valid and pix_valid asserted together -> pix_ready=0, weight byte accepted, FSM enters LOAD_W; after 9 bytes of 0xFF, weight_bus = all 0xFF and weight_valid pulses once.
5. Assert rst_n low after 20 pixels of a frame -> all outputs 0 asynchronously, FSM IDLE, pix_ready=0; no in_valid until weights are reloaded and a new frame starts from pixel (0,0).
6. Two frames back-to-back (second frame pix=63-(row*8+col)) -> 72 windows total; frame_done pulses twice; first window of the second frame = 63,62,61,55,54,53,47,46,45.
